// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the IF->ID bus width and default reset PC (as macros so non-package
// code can use them), plus the queue entry type and a PC alignment helper.
`ifndef FETCH_QUEUE_DEFINES
`define FETCH_QUEUE_DEFINES
`define IF_TO_ID_BUS_WIDTH 64
`define RESET_PC_DEFAULT   32'h0000_0000
`endif

package fetch_queue_pkg;

  localparam int unsigned IF_TO_ID_BUS_W   = `IF_TO_ID_BUS_WIDTH;
  localparam logic [31:0] DEFAULT_RESET_PC = `RESET_PC_DEFAULT;

  // One queue entry; packed so that pc lands in the upper half of the bus.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Instruction fetches are word aligned; low two address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fq_ram.sv
// Fetch queue storage: DEPTH x 64-bit register array.
// Ports: clk; we/waddr/wdata single write port (written on rising edge);
//        raddr/rdata asynchronous read port (combinational, zero latency).
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Contents need no reset: the control logic never reads an entry that
  // has not been written since the last reset or flush.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the IROM and the ID stage.
// Latency: 2 cycles from irom_en to if_to_id_valid on an empty queue;
// sustains 1 instr/cycle. Backpressure: id_allow_in=0 lets the queue fill to
// DEPTH, after which fetch issue stops (irom_en=0) until ID drains an entry.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   redirect_valid, redirect_pc   - EX taken branch/jump: flush and refetch
//   irom_en, irom_adr, irom_inst  - IROM request / 1-cycle-later response
//   id_allow_in                   - ID accepts the head entry this cycle
//   if_to_id_valid, if_to_id_bus  - head entry {pc, inst} and its valid
//   fq_count                      - current queue occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,  // power of two, >= 2
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        irom_en,
  output logic [31:0]                 irom_adr,
  input  logic [31:0]                 irom_inst,
  input  logic                        id_allow_in,
  output logic                        if_to_id_valid,
  output logic [IF_TO_ID_BUS_W-1:0]   if_to_id_bus,
  output logic [$clog2(DEPTH+1)-1:0]  fq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  // State
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  // Per-cycle control
  logic          redirect_now;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;
  logic [31:0]   issue_adr;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;

  always_comb begin
    // A redirect arriving while reset is held must not leak onto the IROM port.
    redirect_now   = redirect_valid & ~rst;

    // The head is hidden during a redirect: it belongs to the wrong path.
    if_to_id_valid = (count_q != '0) & ~redirect_valid;
    pop            = if_to_id_valid & id_allow_in;

    // A response arriving in a redirect cycle is from the wrong path.
    push           = inflight_q & ~redirect_valid;

    // Credit check: entries held plus the one response still owed, less the
    // entry leaving this cycle. Issuing only while this is below DEPTH is what
    // guarantees the queue never overflows. One extra bit holds occ == DEPTH.
    occ            = {1'b0, count_q} + {{CW{1'b0}}, inflight_q}
                   - {{CW{1'b0}}, pop};
    issue          = ~rst & (redirect_now | (occ < DEPTH_OCC));

    issue_adr      = redirect_now ? align_pc(redirect_pc) : fetch_pc_q;

    // Fetch PC wraps naturally modulo 2^32.
    fetch_pc_d     = issue ? (issue_adr + 32'd4) : fetch_pc_q;
    req_pc_d       = issue ? issue_adr : req_pc_q;
    inflight_d     = issue;

    if (redirect_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    wr_entry.pc   = req_pc_q;
    wr_entry.inst = irom_inst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fq_ram #(
    .DEPTH (DEPTH)
  ) u_fq_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_entry)
  );

  assign irom_en      = issue;
  assign irom_adr     = issue_adr;
  assign if_to_id_bus = rd_entry;
  assign fq_count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a pop-side scoreboard.
// The IROM model returns (address ^ INST_XOR) one cycle after each request.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] INST_XOR = 32'hC0DE_0000;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       redirect_valid;
  logic [31:0]                redirect_pc;
  logic                       irom_en;
  logic [31:0]                irom_adr;
  logic [31:0]                irom_inst = 32'hDEAD_BEEF;
  logic                       id_allow_in;
  logic                       if_to_id_valid;
  logic [63:0]                if_to_id_bus;
  logic [$clog2(DEPTH+1)-1:0] fq_count;

  int        errors  = 0;
  int        checks  = 0;
  int        pop_cnt = 0;
  fq_entry_t sb[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irom_en        (irom_en),
    .irom_adr       (irom_adr),
    .irom_inst      (irom_inst),
    .id_allow_in    (id_allow_in),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_bus   (if_to_id_bus),
    .fq_count       (fq_count)
  );

  // IROM: data valid exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (irom_en) irom_inst <= irom_adr ^ INST_XOR;
    else         irom_inst <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Replace the scoreboard with the sequential stream starting at 'start'.
  task automatic expect_run(input logic [31:0] start, input int n);
    fq_entry_t e;
    logic [31:0] pc;
    sb.delete();
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc   = pc;
      e.inst = pc ^ INST_XOR;
      sb.push_back(e);
      pc = pc + 32'd4;
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    fq_entry_t exp_e;
    if (!rst) begin
      chk("valid_rule", if_to_id_valid, (fq_count != 0) && !redirect_valid);
      chk("no_overflow", fq_count <= DEPTH, 1'b1);
      if (if_to_id_valid && id_allow_in) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL pop_unexpected observed=%0h expected=none", if_to_id_bus);
        end else begin
          exp_e = sb.pop_front();
          chk("pop_entry", if_to_id_bus, exp_e);
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_allow_in    = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_irom_en", irom_en, 1'b0);
    chk("rst_count", fq_count, 0);
    chk("rst_valid", if_to_id_valid, 1'b0);
    chk("rst_adr", irom_adr, RST_PC);

    // Fill with ID stalled
    expect_run(RST_PC, 64);
    rst = 1'b0;
    #1;
    chk("first_en", irom_en, 1'b1);
    chk("first_adr", irom_adr, RST_PC);
    tick();
    chk("fill_adr1", irom_adr, 32'd4);
    tick();
    chk("fill_adr2", irom_adr, 32'd8);
    tick();
    chk("fill_adr3", irom_adr, 32'd12);
    chk("fill_cnt3", fq_count, 2);
    tick();
    chk("fill_en4", irom_en, 1'b0);
    chk("fill_cnt4", fq_count, 3);
    tick();
    chk("full_cnt", fq_count, DEPTH);
    chk("full_en", irom_en, 1'b0);
    repeat (3) tick();
    chk("full_hold_cnt", fq_count, DEPTH);
    chk("full_hold_en", irom_en, 1'b0);

    // Drain and stream at full rate
    pop_cnt     = 0;
    id_allow_in = 1'b1;
    repeat (12) tick();
    chk("stream_pops", pop_cnt, 12);
    chk("stream_cnt", fq_count, 3);

    // Redirect to unaligned 0x103 while full-ish with a response in flight
    expect_run(32'h100, 64);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("rd_adr", irom_adr, 32'h100);
    chk("rd_en", irom_en, 1'b1);
    chk("rd_valid", if_to_id_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_cnt_clear", fq_count, 0);
    chk("rd_next_adr", irom_adr, 32'h104);
    pop_cnt = 0;
    repeat (6) tick();
    chk("rd_pops", pop_cnt, 5);

    // Back-to-back redirects: 0x40 then 0x80
    expect_run(32'h80, 64);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_pc    = 32'h80;
    #1;
    chk("bb_adr", irom_adr, 32'h80);
    tick();
    redirect_valid = 1'b0;
    pop_cnt        = 0;
    repeat (6) tick();
    chk("bb_pops", pop_cnt, 5);

    // Fetch PC wrap
    expect_run(32'hFFFF_FFFC, 64);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    chk("wrap_adr0", irom_adr, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_adr1", irom_adr, 32'h0000_0000);
    repeat (5) tick();

    // Reset mid-operation with two entries queued and one in flight
    id_allow_in = 1'b0;
    expect_run(32'h200, 64);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    chk("pre_rst_cnt", fq_count, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", irom_en, 1'b0);
    chk("mid_rst_cnt", fq_count, 0);
    chk("mid_rst_valid", if_to_id_valid, 1'b0);
    chk("mid_rst_adr", irom_adr, RST_PC);
    repeat (2) tick();
    id_allow_in = 1'b1;
    expect_run(RST_PC, 64);
    rst = 1'b0;
    #1;
    chk("rel_en", irom_en, 1'b1);
    chk("rel_adr", irom_adr, RST_PC);
    tick();
    chk("lat_c1_valid", if_to_id_valid, 1'b0);
    tick();
    chk("lat_c2_valid", if_to_id_valid, 1'b1);
    chk("lat_c2_bus", if_to_id_bus, {RST_PC, RST_PC ^ INST_XOR});
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
